// File: rtl/ag_tcu_wmma_sequencer.sv
// ag_tcu_wmma_sequencer
//   Expands one accepted AG-TCU WMMA instruction into M_STEPS*N_STEPS*KC
//   micro-ops, ordered with k innermost, then n, then m. Each uop carries
//   the A, B and C/D register indices for its (m, n, k) step.
//   Illegal formats are rejected with a one-cycle err_valid pulse.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_ready  instruction handshake from the dispatch buffer
//   in_wid, in_tag     warp id and opaque tag, latched at accept
//   in_fmt_s/in_fmt_d  source/destination format ids
//   in_k_cnt           K steps to issue (0 or >K_STEPS selects K_STEPS)
//   out_valid/ready    uop handshake to the dot-product datapath
//   out_wid..out_fmt_d latched instruction fields
//   out_step_m/n/k     current step indices
//   out_ra/rb/rc       register indices for this step
//   out_last_k         final k for this (m,n): D writeback
//   out_last           final uop of the instruction
//   err_valid/err_wid  illegal-format pulse and offending warp
//   busy               instruction in flight
module ag_tcu_wmma_sequencer #(
  parameter int M_STEPS  = 4,
  parameter int N_STEPS  = 4,
  parameter int K_STEPS  = 4,
  parameter int RA_BASE  = 0,
  parameter int RB_BASE  = 16,
  parameter int RC_BASE  = 32,
  parameter int REG_BITS = 6,
  parameter int WID_BITS = 2,
  parameter int TAG_BITS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WID_BITS-1:0]         in_wid,
  input  logic [TAG_BITS-1:0]         in_tag,
  input  logic [3:0]                  in_fmt_s,
  input  logic [3:0]                  in_fmt_d,
  input  logic [$clog2(K_STEPS):0]    in_k_cnt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WID_BITS-1:0]         out_wid,
  output logic [TAG_BITS-1:0]         out_tag,
  output logic [3:0]                  out_fmt_s,
  output logic [3:0]                  out_fmt_d,
  output logic [$clog2(M_STEPS)-1:0]  out_step_m,
  output logic [$clog2(N_STEPS)-1:0]  out_step_n,
  output logic [$clog2(K_STEPS)-1:0]  out_step_k,
  output logic [REG_BITS-1:0]         out_ra,
  output logic [REG_BITS-1:0]         out_rb,
  output logic [REG_BITS-1:0]         out_rc,
  output logic                        out_last_k,
  output logic                        out_last,
  output logic                        err_valid,
  output logic [WID_BITS-1:0]         err_wid,
  output logic                        busy
);

  localparam int MW = $clog2(M_STEPS);
  localparam int NW = $clog2(N_STEPS);
  localparam int KB = $clog2(K_STEPS);
  localparam int KW = KB + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                r_state, w_state_nx;
  logic [MW-1:0]         r_m, w_m_nx;
  logic [NW-1:0]         r_n, w_n_nx;
  logic [KB-1:0]         r_k, w_k_nx;
  logic [KW-1:0]         r_kc;
  logic [WID_BITS-1:0]   r_wid;
  logic [TAG_BITS-1:0]   r_tag;
  logic [3:0]            r_fmt_s;
  logic [3:0]            r_fmt_d;
  logic                  r_err_valid;
  logic [WID_BITS-1:0]   r_err_wid;

  logic                  w_valid;
  logic                  w_fire;
  logic                  w_accept;
  logic                  w_legal;
  logic [KW-1:0]         w_kc;
  logic                  w_last_k;
  logic                  w_n_last;
  logic                  w_m_last;
  logic                  w_last;
  logic [REG_BITS-1:0]   w_ra;
  logic [REG_BITS-1:0]   w_rb;
  logic [REG_BITS-1:0]   w_rc;

  assign w_valid  = (r_state == RUN);
  assign w_fire   = w_valid && out_ready;
  assign w_legal  = (in_fmt_s inside {4'd9, 4'd10, 4'd11, 4'd12}) && (in_fmt_d == 4'd8);
  assign w_kc     = (in_k_cnt == '0 || in_k_cnt > KW'(K_STEPS)) ? KW'(K_STEPS) : in_k_cnt;

  assign w_last_k = ({1'b0, r_k} + KW'(1) == r_kc);
  assign w_n_last = (r_n == NW'(N_STEPS - 1));
  assign w_m_last = (r_m == MW'(M_STEPS - 1));
  assign w_last   = w_last_k && w_n_last && w_m_last;

  // Strides use K_STEPS rather than KC so short-K issue keeps the layout.
  assign w_ra = REG_BITS'(RA_BASE + int'(r_m) * K_STEPS + int'(r_k));
  assign w_rb = REG_BITS'(RB_BASE + int'(r_n) * K_STEPS + int'(r_k));
  assign w_rc = REG_BITS'(RC_BASE + int'(r_m) * N_STEPS + int'(r_n));

  assign in_ready = (r_state == IDLE) || (w_valid && w_last && out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nx = r_state;
    w_m_nx     = r_m;
    w_n_nx     = r_n;
    w_k_nx     = r_k;
    if (w_fire) begin
      if (w_last_k) begin
        w_k_nx = '0;
        if (w_n_last) begin
          w_n_nx = '0;
          if (w_m_last) begin
            w_m_nx     = '0;
            w_state_nx = IDLE;
          end else begin
            w_m_nx = r_m + 1'b1;
          end
        end else begin
          w_n_nx = r_n + 1'b1;
        end
      end else begin
        w_k_nx = r_k + 1'b1;
      end
    end
    // A legal accept overrides the end-of-instruction return to IDLE,
    // giving zero-bubble back-to-back issue.
    if (w_accept && w_legal) begin
      w_state_nx = RUN;
      w_m_nx     = '0;
      w_n_nx     = '0;
      w_k_nx     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_m         <= '0;
      r_n         <= '0;
      r_k         <= '0;
      r_kc        <= '0;
      r_wid       <= '0;
      r_tag       <= '0;
      r_fmt_s     <= '0;
      r_fmt_d     <= '0;
      r_err_valid <= 1'b0;
      r_err_wid   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_m         <= w_m_nx;
      r_n         <= w_n_nx;
      r_k         <= w_k_nx;
      r_err_valid <= w_accept && !w_legal;
      if (w_accept && !w_legal) begin
        r_err_wid <= in_wid;
      end
      if (w_accept && w_legal) begin
        r_kc    <= w_kc;
        r_wid   <= in_wid;
        r_tag   <= in_tag;
        r_fmt_s <= in_fmt_s;
        r_fmt_d <= in_fmt_d;
      end
    end
  end

  assign out_valid  = w_valid;
  assign out_wid    = r_wid;
  assign out_tag    = r_tag;
  assign out_fmt_s  = r_fmt_s;
  assign out_fmt_d  = r_fmt_d;
  assign out_step_m = w_valid ? r_m : '0;
  assign out_step_n = w_valid ? r_n : '0;
  assign out_step_k = w_valid ? r_k : '0;
  assign out_ra     = w_valid ? w_ra : '0;
  assign out_rb     = w_valid ? w_rb : '0;
  assign out_rc     = w_valid ? w_rc : '0;
  assign out_last_k = w_valid && w_last_k;
  assign out_last   = w_valid && w_last;
  assign err_valid  = r_err_valid;
  assign err_wid    = r_err_wid;
  assign busy       = w_valid;

endmodule

// File: tb/tb_ag_tcu_wmma_sequencer.sv
module tb_ag_tcu_wmma_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_wid;
  logic [7:0] in_tag;
  logic [3:0] in_fmt_s;
  logic [3:0] in_fmt_d;
  logic [2:0] in_k_cnt;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_wid;
  logic [7:0] out_tag;
  logic [3:0] out_fmt_s;
  logic [3:0] out_fmt_d;
  logic [1:0] out_step_m;
  logic [1:0] out_step_n;
  logic [1:0] out_step_k;
  logic [5:0] out_ra;
  logic [5:0] out_rb;
  logic [5:0] out_rc;
  logic       out_last_k;
  logic       out_last;
  logic       err_valid;
  logic [1:0] err_wid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ag_tcu_wmma_sequencer #(
    .M_STEPS(4), .N_STEPS(4), .K_STEPS(4),
    .RA_BASE(0), .RB_BASE(16), .RC_BASE(32),
    .REG_BITS(6), .WID_BITS(2), .TAG_BITS(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wid(in_wid), .in_tag(in_tag),
    .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d), .in_k_cnt(in_k_cnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wid(out_wid), .out_tag(out_tag),
    .out_fmt_s(out_fmt_s), .out_fmt_d(out_fmt_d),
    .out_step_m(out_step_m), .out_step_n(out_step_n), .out_step_k(out_step_k),
    .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc),
    .out_last_k(out_last_k), .out_last(out_last),
    .err_valid(err_valid), .err_wid(err_wid), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check the current uop against the reference (m,n,k) with kc = effective K.
  task automatic chk_uop(input string tag, input int m, input int n, input int k, input int kc);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".m"}, out_step_m, m);
    chk({tag, ".n"}, out_step_n, n);
    chk({tag, ".k"}, out_step_k, k);
    chk({tag, ".ra"}, out_ra, (m * 4 + k) % 64);
    chk({tag, ".rb"}, out_rb, (16 + n * 4 + k) % 64);
    chk({tag, ".rc"}, out_rc, (32 + m * 4 + n) % 64);
    chk({tag, ".last_k"}, out_last_k, (k == kc - 1));
    chk({tag, ".last"}, out_last, (k == kc - 1 && n == 3 && m == 3));
  endtask

  task automatic issue(input logic [1:0] wid, input logic [7:0] tag,
                       input logic [3:0] fs, input logic [3:0] fd, input logic [2:0] kc);
    in_valid = 1'b1;
    in_wid   = wid;
    in_tag   = tag;
    in_fmt_s = fs;
    in_fmt_d = fd;
    in_k_cnt = kc;
  endtask

  initial begin
    int hs;
    int cyc;
    int cnt;
    logic [5:0] s_ra;
    logic [1:0] s_k;
    logic       s_stall;

    reset = 1'b1;
    in_valid = 1'b0; in_wid = '0; in_tag = '0; in_fmt_s = '0; in_fmt_d = '0; in_k_cnt = '0;
    out_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.err_valid", err_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_rb", out_rb, 0);
    chk("rst.out_rc", out_rc, 0);
    chk("rst.out_tag", out_tag, 0);
    reset = 1'b0;
    tick();

    // Full instruction: i8/i32, k_cnt=0 -> 64 uops
    out_ready = 1'b1;
    issue(2'd1, 8'h5A, 4'd9, 4'd8, 3'd0);
    tick();
    in_valid = 1'b0;
    chk("full.wid", out_wid, 1);
    chk("full.tag", out_tag, 8'h5A);
    chk("full.fmt_s", out_fmt_s, 9);
    chk("full.busy", busy, 1);
    for (int i = 0; i < 64; i++) begin
      chk_uop($sformatf("full[%0d]", i), i / 16, (i / 4) % 4, i % 4, 4);
      tick();
    end
    chk("full.end_valid", out_valid, 0);
    chk("full.end_busy", busy, 0);
    chk("full.end_in_ready", in_ready, 1);

    // Short K: u4/i32, k_cnt=2 -> 32 uops
    issue(2'd0, 8'h11, 4'd12, 4'd8, 3'd2);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk_uop($sformatf("short[%0d]", i), i / 8, (i / 2) % 4, i % 2, 2);
      tick();
    end
    chk("short.end_valid", out_valid, 0);

    // k_cnt above K_STEPS selects K_STEPS -> 64 uops
    issue(2'd0, 8'h22, 4'd11, 4'd8, 3'd7);
    tick();
    in_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200 && out_valid; c++) begin
      cnt++;
      tick();
    end
    chk("kover.count", cnt, 64);

    // Back-pressure: random out_ready, 64 handshakes, stable while stalled
    issue(2'd2, 8'h33, 4'd10, 4'd8, 3'd0);
    tick();
    in_valid = 1'b0;
    hs = 0; cyc = 0; s_stall = 1'b0; s_ra = '0; s_k = '0;
    while (hs < 64 && cyc < 1000) begin
      out_ready = (cyc % 4 == 0 || cyc % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      chk_uop($sformatf("bp[%0d]", hs), hs / 16, (hs / 4) % 4, hs % 4, 4);
      if (s_stall) begin
        chk("bp.stable_ra", out_ra, s_ra);
        chk("bp.stable_k", out_step_k, s_k);
      end
      s_stall = !out_ready;
      s_ra = out_ra;
      s_k  = out_step_k;
      if (out_ready) hs++;
      cyc++;
      @(posedge clk);
      #1;
    end
    chk("bp.handshakes", hs, 64);
    out_ready = 1'b1;
    #1;
    chk("bp.end_valid", out_valid, 0);
    tick();

    // Back-to-back: second instruction held valid during the first's last uop
    issue(2'd0, 8'h01, 4'd10, 4'd8, 3'd1);
    tick();
    issue(2'd3, 8'h77, 4'd9, 4'd8, 3'd0);
    for (int i = 0; i < 16; i++) begin
      chk_uop($sformatf("b2b_a[%0d]", i), i / 4, i % 4, 0, 1);
      chk($sformatf("b2b_a[%0d].in_ready", i), in_ready, (i == 15));
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_b.wid", out_wid, 3);
    chk("b2b_b.tag", out_tag, 8'h77);
    for (int i = 0; i < 64; i++) begin
      chk_uop($sformatf("b2b_b[%0d]", i), i / 16, (i / 4) % 4, i % 4, 4);
      tick();
    end
    chk("b2b.end_valid", out_valid, 0);

    // Illegal formats
    issue(2'd2, 8'h44, 4'd8, 4'd8, 3'd0);
    tick();
    in_valid = 1'b0;
    chk("ill_s.err_valid", err_valid, 1);
    chk("ill_s.err_wid", err_wid, 2);
    chk("ill_s.out_valid", out_valid, 0);
    chk("ill_s.in_ready", in_ready, 1);
    tick();
    chk("ill_s.err_pulse", err_valid, 0);
    chk("ill_s.busy", busy, 0);
    issue(2'd2, 8'h45, 4'd9, 4'd9, 3'd0);
    tick();
    in_valid = 1'b0;
    chk("ill_d.err_valid", err_valid, 1);
    chk("ill_d.err_wid", err_wid, 2);
    chk("ill_d.out_valid", out_valid, 0);
    tick();
    chk("ill_d.err_pulse", err_valid, 0);
    chk("ill_d.out_valid2", out_valid, 0);

    // Reset mid-instruction at uop 20
    issue(2'd1, 8'h66, 4'd9, 4'd8, 3'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk_uop("mid[20]", 1, 1, 0, 4);
    reset = 1'b1;
    tick();
    chk("mid.out_valid", out_valid, 0);
    chk("mid.busy", busy, 0);
    chk("mid.in_ready", in_ready, 1);
    reset = 1'b0;
    issue(2'd0, 8'h99, 4'd9, 4'd8, 3'd0);
    tick();
    in_valid = 1'b0;
    chk_uop("restart[0]", 0, 0, 0, 4);
    chk("restart.tag", out_tag, 8'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
